// File: rtl/unswap2_sync.sv
// unswap2_sync: accepts a 4-phase token pair plus a swap control bit, undoes the
// swap, and re-emits both tokens on two independent 4-phase output channels.
module unswap2_sync #(
   parameter int N = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         r_i,
   output logic         a_i,
   input  logic [N-1:0] d_i,
   input  logic         r1_i,
   output logic         a1_i,
   input  logic [N-1:0] d1_i,
   input  logic         rctl_i,
   input  logic         dctl_i,
   output logic         actl_i,
   output logic         r_o,
   input  logic         a_o,
   output logic [N-1:0] d_o,
   output logic         r1_o,
   input  logic         a1_o,
   output logic [N-1:0] d1_o
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t       r_state;
   state_t       w_state_nxt;
   logic         r_ack;
   logic         r_req0;
   logic         r_req1;
   logic [N-1:0] r_dat0;
   logic [N-1:0] r_dat1;

   logic         w_all_req;
   logic         w_no_req;
   logic         w_done;
   logic         w_capture;
   logic         w_ack_nxt;
   logic         w_req0_nxt;
   logic         w_req1_nxt;
   logic [N-1:0] w_dat0_nxt;
   logic [N-1:0] w_dat1_nxt;

   assign w_all_req = r_i & r1_i & rctl_i;
   assign w_no_req  = ~(r_i | r1_i | rctl_i);
   // An output channel is complete only once its request is low and its ack was seen low.
   assign w_done    = ~r_ack & ~r_req0 & ~a_o & ~r_req1 & ~a1_o;
   assign w_capture = (r_state == IDLE) & w_all_req;

   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      // NOTE: default assignment first so no path through this block infers a latch.
      w_state_nxt = r_state;
      if (r_state == IDLE) begin
         if (w_all_req) w_state_nxt = BUSY;
      end else begin
         if (w_done) w_state_nxt = IDLE;
      end
   end

   always_comb begin
      w_ack_nxt  = r_ack;
      w_req0_nxt = r_req0;
      w_req1_nxt = r_req1;
      w_dat0_nxt = r_dat0;
      w_dat1_nxt = r_dat1;
      if (w_capture) begin
         w_ack_nxt  = 1'b1;
         w_req0_nxt = 1'b1;
         w_req1_nxt = 1'b1;
         w_dat0_nxt = dctl_i ? d1_i : d_i;
         w_dat1_nxt = dctl_i ? d_i  : d1_i;
      end else if (r_state == BUSY) begin
         // Acks only ever fall in BUSY; early requests for the next token wait for IDLE.
         if (w_no_req)       w_ack_nxt  = 1'b0;
         if (r_req0 && a_o)  w_req0_nxt = 1'b0;
         if (r_req1 && a1_o) w_req1_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ack  <= 1'b0;
         r_req0 <= 1'b0;
         r_req1 <= 1'b0;
         r_dat0 <= '0;
         r_dat1 <= '0;
      end else begin
         r_ack  <= w_ack_nxt;
         r_req0 <= w_req0_nxt;
         r_req1 <= w_req1_nxt;
         r_dat0 <= w_dat0_nxt;
         r_dat1 <= w_dat1_nxt;
      end
   end

   assign a_i    = r_ack;
   assign a1_i   = r_ack;
   assign actl_i = r_ack;
   assign r_o    = r_req0;
   assign r1_o   = r_req1;
   assign d_o    = r_dat0;
   assign d1_o   = r_dat1;

endmodule

// File: tb/tb_unswap2_sync.sv
// Self-checking bench for unswap2_sync: table-driven token pairs with a data
// scoreboard, plus hand-written multi-cycle handshake corner cases.
module tb_unswap2_sync;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         r_i, r1_i, rctl_i, dctl_i, a_o, a1_o;
   logic [N-1:0] d_i, d1_i;
   logic         a_i, a1_i, actl_i, r_o, r1_o;
   logic [N-1:0] d_o, d1_o;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [N-1:0] d0;
      logic [N-1:0] d1;
   } pair_t;

   typedef struct {
      logic [N-1:0] d0;
      logic [N-1:0] d1;
      logic         ctl;
      logic [N-1:0] exp0;
      logic [N-1:0] exp1;
   } vec_t;

   pair_t sb_q[$];
   vec_t  vecs[4];

   unswap2_sync #(.N(N)) dut (
      .clk(clk), .rst(rst),
      .r_i(r_i), .a_i(a_i), .d_i(d_i),
      .r1_i(r1_i), .a1_i(a1_i), .d1_i(d1_i),
      .rctl_i(rctl_i), .dctl_i(dctl_i), .actl_i(actl_i),
      .r_o(r_o), .a_o(a_o), .d_o(d_o),
      .r1_o(r1_o), .a1_o(a1_o), .d1_o(d1_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive a token on all three input channels and queue the expected output pair.
   task automatic drive_token(input logic [N-1:0] d0, input logic [N-1:0] d1, input logic ctl,
                              input logic [N-1:0] e0, input logic [N-1:0] e1);
      pair_t p;
      d_i = d0; d1_i = d1; dctl_i = ctl;
      r_i = 1'b1; r1_i = 1'b1; rctl_i = 1'b1;
      p.d0 = e0; p.d1 = e1;
      sb_q.push_back(p);
   endtask

   // Called just after the capture edge: all handshakes up, data matches scoreboard head.
   task automatic check_capture(input string tag);
      pair_t p;
      check({tag, "_a_i"}, a_i, 1);
      check({tag, "_a1_i"}, a1_i, 1);
      check({tag, "_actl_i"}, actl_i, 1);
      check({tag, "_r_o"}, r_o, 1);
      check({tag, "_r1_o"}, r1_o, 1);
      if (sb_q.size() == 0) begin
         check({tag, "_sb_empty"}, 1, 0);
      end else begin
         p = sb_q.pop_front();
         check({tag, "_d_o"}, d_o, p.d0);
         check({tag, "_d1_o"}, d1_o, p.d1);
      end
   endtask

   // Release inputs, ack both outputs, wait (bounded) for everything to fall, return to IDLE.
   task automatic finish_token(input string tag);
      int n;
      r_i = 1'b0; r1_i = 1'b0; rctl_i = 1'b0;
      a_o = 1'b1; a1_o = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
      end while ((r_o || r1_o || a_i) && n < 20);
      check({tag, "_release_timeout"}, (r_o || r1_o || a_i), 0);
      a_o = 1'b0; a1_o = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      rst = 1'b1;
      r_i = 0; r1_i = 0; rctl_i = 0; dctl_i = 0; a_o = 0; a1_o = 0;
      d_i = '0; d1_i = '0;

      vecs[0] = '{d0: 8'h11, d1: 8'h22, ctl: 1'b0, exp0: 8'h11, exp1: 8'h22};
      vecs[1] = '{d0: 8'h11, d1: 8'h22, ctl: 1'b1, exp0: 8'h22, exp1: 8'h11};
      vecs[2] = '{d0: 8'hA5, d1: 8'h3C, ctl: 1'b1, exp0: 8'h3C, exp1: 8'hA5};
      vecs[3] = '{d0: 8'hFF, d1: 8'h00, ctl: 1'b0, exp0: 8'hFF, exp1: 8'h00};

      tick();
      tick();
      rst = 1'b0;
      check("rst_a_i", a_i, 0);
      check("rst_actl_i", actl_i, 0);
      check("rst_r_o", r_o, 0);
      check("rst_r1_o", r1_o, 0);
      check("rst_d_o", d_o, 0);
      check("rst_d1_o", d1_o, 0);
      tick();

      // Table: straight and unswapped pairs, one-cycle capture latency, data held afterwards.
      for (int i = 0; i < 4; i++) begin
         drive_token(vecs[i].d0, vecs[i].d1, vecs[i].ctl, vecs[i].exp0, vecs[i].exp1);
         tick();
         check_capture($sformatf("vec%0d", i));
         finish_token($sformatf("vec%0d", i));
         check($sformatf("vec%0d_hold_d_o", i), d_o, vecs[i].exp0);
         check($sformatf("vec%0d_hold_d1_o", i), d1_o, vecs[i].exp1);
      end

      // Partial arrival: r1_i late by 5 cycles, nothing captured until it rises.
      d_i = 8'h5A; d1_i = 8'hC3; dctl_i = 1'b1;
      r_i = 1'b1; rctl_i = 1'b1; r1_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("partial%0d_a_i", i), a_i, 0);
         check($sformatf("partial%0d_r_o", i), r_o, 0);
      end
      drive_token(8'h5A, 8'hC3, 1'b1, 8'hC3, 8'h5A);
      tick();
      check_capture("partial");
      finish_token("partial");

      // Skewed output acks with early input release and an early second token.
      drive_token(8'h01, 8'h02, 1'b0, 8'h01, 8'h02);
      tick();
      check_capture("skew");
      r_i = 0; r1_i = 0; rctl_i = 0;
      a_o = 1'b1;
      tick();
      check("skew_r_o_fall", r_o, 0);
      check("skew_r1_o_held", r1_o, 1);
      check("skew_ack_fall", a_i, 0);
      a_o = 1'b0;
      drive_token(8'h33, 8'h44, 1'b1, 8'h44, 8'h33);
      for (int i = 0; i < 9; i++) begin
         tick();
         check($sformatf("skew_wait%0d_a_i", i), a_i, 0);
         check($sformatf("skew_wait%0d_r1_o", i), r1_o, 1);
      end
      a1_o = 1'b1;
      tick();
      check("skew_r1_o_fall", r1_o, 0);
      check("skew_no_accept_a1_hi", a_i, 0);
      tick();
      check("skew_no_accept_a1_hi2", a_i, 0);
      a1_o = 1'b0;
      tick();
      check("skew_no_accept_to_idle", a_i, 0);
      tick();
      check_capture("skew2");
      finish_token("skew2");

      // Input release ordering: rctl_i held 3 cycles after the data requests drop.
      drive_token(8'h77, 8'h88, 1'b0, 8'h77, 8'h88);
      tick();
      check_capture("order");
      r_i = 0; r1_i = 0;
      a_o = 1'b1; a1_o = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("order%0d_a_i", i), a_i, 1);
         check($sformatf("order%0d_actl_i", i), actl_i, 1);
      end
      rctl_i = 1'b0;
      tick();
      check("order_a_i_fall", a_i, 0);
      check("order_a1_i_fall", a1_o ? a1_i : 1'b1, 0);
      check("order_actl_i_fall", actl_i, 0);
      a_o = 1'b0; a1_o = 1'b0;
      tick();
      tick();

      // Reset while BUSY discards the in-flight token; a fresh token then works.
      drive_token(8'h9E, 8'h6B, 1'b1, 8'h6B, 8'h9E);
      tick();
      check_capture("midrst");
      rst = 1'b1;
      r_i = 0; r1_i = 0; rctl_i = 0;
      tick();
      rst = 1'b0;
      check("midrst_a_i", a_i, 0);
      check("midrst_actl_i", actl_i, 0);
      check("midrst_r_o", r_o, 0);
      check("midrst_r1_o", r1_o, 0);
      check("midrst_d_o", d_o, 0);
      check("midrst_d1_o", d1_o, 0);
      tick();
      drive_token(8'hDE, 8'hAD, 1'b0, 8'hDE, 8'hAD);
      tick();
      check_capture("postrst");
      finish_token("postrst");

      check("sb_drained", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
